// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - shared types and boot-table defaults for the HyperBus controller
package hyperbus_pkg;

  localparam int CfgRegAddrWidth = 32;
  localparam int CfgRegDataWidth = 32;

  typedef struct packed {
    logic [CfgRegAddrWidth-1:0]   addr;
    logic                         write;
    logic [CfgRegDataWidth-1:0]   wdata;
    logic [CfgRegDataWidth/8-1:0] wstrb;
    logic                         valid;
  } cfg_reg_req_t;

  typedef struct packed {
    logic [CfgRegDataWidth-1:0] rdata;
    logic                       error;
    logic                       ready;
  } cfg_reg_rsp_t;

  typedef enum logic [1:0] {
    CFG_BOOT_WAIT,
    CFG_BOOT_WRITE,
    CFG_BOOT_DONE
  } cfg_boot_state_e;

  // Boot table: timing, latency, address space, PHY select (index 0 first).
  localparam int CfgBootNumInit = 4;

  localparam logic [CfgBootNumInit-1:0][CfgRegAddrWidth-1:0] CfgBootAddr = {
    32'h0000_000C,
    32'h0000_0008,
    32'h0000_0004,
    32'h0000_0000
  };

  localparam logic [CfgBootNumInit-1:0][CfgRegDataWidth-1:0] CfgBootData = {
    32'h0000_0001,
    32'h0000_0002,
    32'h0000_0006,
    32'h0003_0306
  };

endpackage

// File: rtl/hyperbus_cfg_boot.sv
// rtl/hyperbus_cfg_boot.sv - boot-time config write sequencer with register-bus pass-through
module hyperbus_cfg_boot
  import hyperbus_pkg::*;
#(
  parameter int RegAddrWidth = CfgRegAddrWidth,
  parameter int RegDataWidth = CfgRegDataWidth,
  parameter type reg_req_t = cfg_reg_req_t,
  parameter type reg_rsp_t = cfg_reg_rsp_t,
  parameter int NumInit = CfgBootNumInit,
  parameter logic [NumInit-1:0][RegAddrWidth-1:0] InitAddr = '0,
  parameter logic [NumInit-1:0][RegDataWidth-1:0] InitData = '0,
  parameter int StartDelay = 16,
  localparam int ErrW = (NumInit > 0) ? $clog2(NumInit + 1) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  reg_req_t        ext_req_i,
  output reg_rsp_t        ext_rsp_o,
  output reg_req_t        reg_req_o,
  input  reg_rsp_t        reg_rsp_i,
  output logic            done_o,
  output logic            error_o,
  output logic [ErrW-1:0] err_cnt_o
);

  localparam int CntW = (StartDelay > 0) ? $clog2(StartDelay + 1) : 1;
  localparam int IdxW = (NumInit > 1) ? $clog2(NumInit) : 1;

  localparam logic [CntW-1:0] DelayInit = CntW'(StartDelay);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'((NumInit > 0) ? NumInit - 1 : 0);
  localparam logic [ErrW-1:0] ErrMax    = ErrW'(NumInit);

  cfg_boot_state_e state_q, state_d, state_eff;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            error_q, error_d;
  logic [ErrW-1:0] err_cnt_q, err_cnt_d;

  assign error_o   = error_q;
  assign err_cnt_o = err_cnt_q;

  // State, delay counter, table index and error bookkeeping; reset restarts the whole table.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CFG_BOOT_WAIT;
      cnt_q     <= DelayInit;
      idx_q     <= '0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next state, boot write request and zero-latency pass-through once done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    error_d   = error_q;
    err_cnt_d = err_cnt_q;
    reg_req_o = '0;
    ext_rsp_o = '0;
    done_o    = 1'b0;

    // WAIT with the counter already at zero only happens straight out of reset
    // with StartDelay=0; it acts as the state it would have moved to, so the
    // first write (or pass-through) is available in cycle 0.
    state_eff = state_q;
    if (state_q == CFG_BOOT_WAIT && cnt_q == '0) begin
      if (NumInit > 0) state_eff = CFG_BOOT_WRITE;
      else             state_eff = CFG_BOOT_DONE;
    end

    case (state_eff)
      CFG_BOOT_WAIT: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          if (NumInit > 0) state_d = CFG_BOOT_WRITE;
          else             state_d = CFG_BOOT_DONE;
        end
      end
      CFG_BOOT_WRITE: begin
        state_d         = CFG_BOOT_WRITE;
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b1;
        reg_req_o.wstrb = '1;
        reg_req_o.addr  = InitAddr[idx_q];
        reg_req_o.wdata = InitData[idx_q];
        if (reg_rsp_i.ready) begin
          if (reg_rsp_i.error) begin
            error_d = 1'b1;
            if (err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + ErrW'(1);
          end
          if (idx_q == LastIdx) state_d = CFG_BOOT_DONE;
          else                  idx_d   = idx_q + IdxW'(1);
        end
      end
      default: begin
        state_d   = CFG_BOOT_DONE;
        done_o    = 1'b1;
        reg_req_o = ext_req_i;
        ext_rsp_o = reg_rsp_i;
      end
    endcase
  end

endmodule

// File: tb/tb_hyperbus_cfg_boot.sv
// tb/tb_hyperbus_cfg_boot.sv - randomized self-checking bench for hyperbus_cfg_boot
module tb_hyperbus_cfg_boot;
  import hyperbus_pkg::*;

  localparam int N  = 4;
  localparam int SD = 16;
  localparam logic [N-1:0][31:0] T_ADDR = {32'h0000_010C, 32'h0000_0108, 32'h0000_0104, 32'h0000_0100};
  localparam logic [N-1:0][31:0] T_DATA = {32'hD00D_0004, 32'hC0DE_0003, 32'hBEEF_0002, 32'hA5A5_0001};

  logic clk = 1'b0;
  logic rst_i = 1'b1;

  cfg_reg_req_t ext_req, reg_req, b_ext_req, b_reg_req;
  cfg_reg_rsp_t ext_rsp, reg_rsp, b_ext_rsp, b_reg_rsp;
  logic         done, error, b_done, b_error;
  logic [2:0]   err_cnt;
  logic [0:0]   b_err_cnt;

  int total = 0;
  int bad   = 0;

  int stall [N];
  bit errf  [N];

  // free-running system clock
  always #5 clk = ~clk;

  hyperbus_cfg_boot #(
    .RegAddrWidth(32), .RegDataWidth(32),
    .reg_req_t(cfg_reg_req_t), .reg_rsp_t(cfg_reg_rsp_t),
    .NumInit(N), .InitAddr(T_ADDR), .InitData(T_DATA), .StartDelay(SD)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .ext_req_i(ext_req), .ext_rsp_o(ext_rsp),
    .reg_req_o(reg_req), .reg_rsp_i(reg_rsp),
    .done_o(done), .error_o(error), .err_cnt_o(err_cnt)
  );

  hyperbus_cfg_boot #(
    .RegAddrWidth(32), .RegDataWidth(32),
    .reg_req_t(cfg_reg_req_t), .reg_rsp_t(cfg_reg_rsp_t),
    .NumInit(0), .StartDelay(0)
  ) u_dut_empty (
    .clk_i(clk), .rst_i(rst_i),
    .ext_req_i(b_ext_req), .ext_rsp_o(b_ext_rsp),
    .reg_req_o(b_reg_req), .reg_rsp_i(b_reg_rsp),
    .done_o(b_done), .error_o(b_error), .err_cnt_o(b_err_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_random();
    ext_req.addr    = $urandom;
    ext_req.write   = 1'($urandom);
    ext_req.wdata   = $urandom;
    ext_req.wstrb   = 4'($urandom);
    ext_req.valid   = 1'($urandom);
    reg_rsp.rdata   = $urandom;
    reg_rsp.error   = 1'($urandom);
    reg_rsp.ready   = 1'($urandom);
    b_ext_req.addr  = $urandom;
    b_ext_req.write = 1'($urandom);
    b_ext_req.wdata = $urandom;
    b_ext_req.wstrb = 4'($urandom);
    b_ext_req.valid = 1'($urandom);
    b_reg_rsp.rdata = $urandom;
    b_reg_rsp.error = 1'($urandom);
    b_reg_rsp.ready = 1'($urandom);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < N; i++) begin
      stall[i] = 0;
      errf[i]  = 1'b0;
    end
  endtask

  // Model: write i is presented from start_c[i] for stall[i]+1 cycles and accepted
  // in its last one; the next write starts the cycle after; done follows the last accept.
  task automatic boot_run(input int n_cycles, input int reset_len, input int ext_hold_from, input bit full);
    int start_c [N];
    int acc_c   [N];
    int nxt, done_c, hs, idx, ecnt;
    cfg_reg_req_t hold_req;
    nxt = SD;
    for (int i = 0; i < N; i++) begin
      start_c[i] = nxt;
      acc_c[i]   = nxt + stall[i];
      nxt        = acc_c[i] + 1;
    end
    done_c = nxt;
    hs = 0;
    hold_req = '0;
    hold_req.valid = 1'b1;
    hold_req.addr  = 32'h0000_0104;

    for (int k = 0; k < reset_len; k++) begin
      @(posedge clk); #1;
      rst_i = 1'b1;
      drive_random();
      @(negedge clk);
      if (k > 0) begin
        chk("rst_valid", reg_req.valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_ext_ready", ext_rsp.ready, 1'b0);
      end
    end

    for (int c = 0; c < n_cycles; c++) begin
      @(posedge clk); #1;
      rst_i = 1'b0;
      drive_random();
      idx = -1;
      for (int i = 0; i < N; i++)
        if (c >= start_c[i] && c <= acc_c[i]) idx = i;
      if (idx >= 0) begin
        reg_rsp.ready = (c == acc_c[idx]);
        if (reg_rsp.ready) reg_rsp.error = errf[idx];
      end
      if (ext_hold_from >= 0 && c >= ext_hold_from) ext_req = hold_req;
      ecnt = 0;
      for (int i = 0; i < N; i++)
        if (acc_c[i] < c && errf[i]) ecnt++;
      @(negedge clk);
      chk("done", done, c >= done_c);
      chk("err_cnt", err_cnt, ecnt);
      chk("error", error, ecnt > 0);
      if (c >= done_c) begin
        chk("pass_req", reg_req, ext_req);
        chk("pass_rsp", ext_rsp, reg_rsp);
      end else begin
        chk("ext_rsp_held", ext_rsp, 0);
        chk("boot_valid", reg_req.valid, idx >= 0);
        if (idx >= 0) begin
          chk("boot_addr", reg_req.addr, T_ADDR[idx]);
          chk("boot_wdata", reg_req.wdata, T_DATA[idx]);
          chk("boot_write", reg_req.write, 1'b1);
          chk("boot_wstrb", reg_req.wstrb, 4'hF);
        end
        if (reg_req.valid && reg_rsp.ready) hs++;
      end
      chk("empty_done", b_done, 1'b1);
      chk("empty_pass_req", b_reg_req, b_ext_req);
      chk("empty_pass_rsp", b_ext_rsp, b_reg_rsp);
      chk("empty_err_cnt", {b_error, b_err_cnt}, 0);
    end
    if (full) chk("handshakes", hs, N);
  endtask

  initial begin
    ext_req   = '0;
    reg_rsp   = '0;
    b_ext_req = '0;
    b_reg_rsp = '0;

    // nominal: writes in cycles 16..19, done at 20
    clear_plan();
    boot_run(26, 2, -1, 1'b1);

    // backpressure: three ready-low cycles on write 2, done at 23
    clear_plan();
    stall[2] = 3;
    boot_run(28, 2, -1, 1'b1);

    // error responses on writes 1 and 3
    clear_plan();
    errf[1] = 1'b1;
    errf[3] = 1'b1;
    boot_run(26, 2, -1, 1'b1);

    // SoC read held from cycle 5; forwarded at cycle 20
    clear_plan();
    boot_run(26, 2, 5, 1'b1);

    // reset pulsed at cycle 18 after an errored first write; full restart
    clear_plan();
    errf[0] = 1'b1;
    boot_run(18, 2, -1, 1'b0);
    boot_run(26, 1, -1, 1'b1);

    // randomized stall/error plans and external traffic
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        stall[i] = $urandom_range(4, 0);
        errf[i]  = 1'($urandom);
      end
      boot_run(SD + N + 24, 2, (r % 2 == 1) ? int'($urandom_range(20, 0)) : -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
